// File: rtl/i2s_pkg.sv
// Shared types and default parameters for the I2S master receiver.
package i2s_pkg;

    // Bus sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    localparam int unsigned DEF_CLK_DIV     = 4;
    localparam int unsigned DEF_WIDTH       = 24;
    localparam int unsigned DEF_SLOT_BITS   = 32;
    localparam int unsigned DEF_DATA_OFFSET = 2;

endpackage

// File: rtl/i2s_clkgen.sv
// SCK generator: divides clk_i by 2*CLK_DIV and flags each SCK edge.
// The strobes are combinational so the consumer acts on the same clk_i
// edge at which sck_o actually changes.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run,
    output logic sck_o,
    output logic sck_rise,
    output logic sck_fall
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          sck_q, sck_d;
    logic          tick;

    // Divider and SCK toggle; held at zero/low while not running.
    always_comb begin
        div_d = div_q;
        sck_d = sck_q;
        tick  = run && (div_q == DIV_MAX);
        if (!run) begin
            div_d = '0;
            sck_d = 1'b0;
        end else if (tick) begin
            div_d = '0;
            sck_d = ~sck_q;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // Divider and SCK registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
            sck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o    = sck_q;
    assign sck_rise = tick && !sck_q;
    assign sck_fall = tick && sck_q;

endmodule

// File: rtl/i2s_master_rx.sv
// I2S bus master/receiver: drives SCK/WS, deserializes SD into left/right
// PCM pairs and hands them out over valid/ready. Stops only on a frame
// boundary so the last frame is always completed.
module i2s_master_rx
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned SLOT_BITS   = DEF_SLOT_BITS,
    parameter int unsigned DATA_OFFSET = DEF_DATA_OFFSET
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    output logic             sck_o,
    output logic             ws_o,
    input  logic             sd_i,
    output logic [WIDTH-1:0] left_o,
    output logic [WIDTH-1:0] right_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overrun_o,
    output logic             busy_o
);

    // Counts rising edges in a slot; must be able to hold SLOT_BITS itself.
    localparam int unsigned CW = $clog2(SLOT_BITS + 1);
    localparam logic [CW-1:0] SLOT_C = CW'(SLOT_BITS);
    localparam logic [CW-1:0] MSB_C  = CW'(DATA_OFFSET);
    localparam logic [CW-1:0] LSB_C  = CW'(DATA_OFFSET + WIDTH - 1);

    state_e           state_q, state_d;
    logic             ws_q, ws_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             lead_in_q, lead_in_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] stage_q, stage_d;
    logic             pair_done_q, pair_done_d;
    logic [WIDTH-1:0] left_q, left_d;
    logic [WIDTH-1:0] right_q, right_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic             sck_rise, sck_fall;
    logic             slot_end;
    logic             capture_win;
    logic [WIDTH-1:0] shifted;

    i2s_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .run      (state_q != ST_IDLE),
        .sck_o    (sck_o),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    assign slot_end    = sck_fall && (lead_in_q || (bit_cnt_q == SLOT_C));
    assign capture_win = (bit_cnt_q >= MSB_C) && (bit_cnt_q <= LSB_C);
    assign shifted     = {shift_q[WIDTH-2:0], sd_i};

    // Run/stop sequencing; STOP leaves only at the fall that would open a left slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable_i) state_d = ST_RUN;
            ST_RUN:  if (!enable_i) state_d = ST_STOP;
            ST_STOP: begin
                if (enable_i)
                    state_d = ST_RUN;
                else if (slot_end && ws_q)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Slot framing, WS generation and serial capture into shift/staging.
    always_comb begin
        ws_d        = ws_q;
        bit_cnt_d   = bit_cnt_q;
        lead_in_d   = lead_in_q;
        shift_d     = shift_q;
        stage_d     = stage_q;
        pair_done_d = 1'b0;
        // Idle and the terminating fall share one path: WS parked high,
        // counters cleared and the lead-in re-armed for the next start.
        if (state_q == ST_IDLE || state_d == ST_IDLE) begin
            ws_d      = 1'b1;
            bit_cnt_d = '0;
            lead_in_d = 1'b1;
        end else if (slot_end) begin
            ws_d      = ~ws_q;
            bit_cnt_d = '0;
            lead_in_d = 1'b0;
        end else if (sck_rise && !lead_in_q) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (capture_win) begin
                shift_d = shifted;
                if (bit_cnt_q == LSB_C) begin
                    if (ws_q)
                        pair_done_d = 1'b1;
                    else
                        stage_d = shifted;
                end
            end
        end
    end

    // Output handshake: load a completed pair, or drop it and flag overrun.
    always_comb begin
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && ready_i)
            valid_d = 1'b0;
        if (pair_done_q) begin
            if (!valid_q || ready_i) begin
                left_d  = stage_q;
                right_d = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // All state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ws_q        <= 1'b1;
            bit_cnt_q   <= '0;
            lead_in_q   <= 1'b1;
            shift_q     <= '0;
            stage_q     <= '0;
            pair_done_q <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ws_q        <= ws_d;
            bit_cnt_q   <= bit_cnt_d;
            lead_in_q   <= lead_in_d;
            shift_q     <= shift_d;
            stage_q     <= stage_d;
            pair_done_q <= pair_done_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign ws_o      = ws_q;
    assign left_o    = left_q;
    assign right_o   = right_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;
    assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2s_master_rx.sv
// Bench for i2s_master_rx: a PCM emulator follows SCK/WS and serializes
// frames; each frame's expected pair is queued when its left slot starts
// and compared against the DUT outputs while valid_o is high.
module tb_i2s_master_rx;

    localparam int W     = 24;
    localparam int OFF   = 2;
    localparam int FRAME = 512;

    typedef struct packed {
        logic [W-1:0] lft;
        logic [W-1:0] rgt;
    } pair_t;

    logic         clk, rst_i, enable_i, sd_i, ready_i;
    logic         sck_o, ws_o, valid_o, overrun_o, busy_o;
    logic [W-1:0] left_o, right_o;

    logic         m_enable, m_sd, m_ready;
    logic         m_sck, m_ws, m_valid, m_overrun, m_busy;
    logic [W-1:0] m_left, m_right;

    pair_t        exp_q[$];
    pair_t        src_q[$];
    int           n_checks, n_fail;
    int           got_cnt, ovr_cnt, frame_no, drop_a, drop_b;
    int           cyc, d_last, d_prev;
    logic [W-1:0] last_l, last_r;
    logic         snd_prev_ws;

    i2s_master_rx u_dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .enable_i  (enable_i),
        .sck_o     (sck_o),
        .ws_o      (ws_o),
        .sd_i      (sd_i),
        .left_o    (left_o),
        .right_o   (right_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .overrun_o (overrun_o),
        .busy_o    (busy_o)
    );

    i2s_master_rx #(.DATA_OFFSET(1)) u_mic (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .enable_i  (m_enable),
        .sck_o     (m_sck),
        .ws_o      (m_ws),
        .sd_i      (m_sd),
        .left_o    (m_left),
        .right_o   (m_right),
        .valid_o   (m_valid),
        .ready_i   (m_ready),
        .overrun_o (m_overrun),
        .busy_o    (m_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    // PCM emulator for the DUT (MSB at rising edge OFF, dummy bits random).
    initial begin : emu
        int    idx;
        logic  ch;
        pair_t cur;
        idx = 0;
        cur = '0;
        sd_i = 1'b0;
        forever begin
            @(negedge sck_o);
            #1;
            if (!rst_i) begin
                ch = ws_o;
                if (ch !== snd_prev_ws) begin
                    idx = 0;
                    if (ch == 1'b0) begin
                        frame_no++;
                        if (src_q.size() != 0)
                            cur = src_q.pop_front();
                        else
                            cur = {24'($urandom), 24'($urandom)};
                        if (frame_no != drop_a && frame_no != drop_b)
                            exp_q.push_back(cur);
                    end
                end else begin
                    idx++;
                end
                snd_prev_ws = ch;
                repeat (2) @(posedge clk);
                if (idx >= OFF && idx < OFF + W)
                    sd_i = ch ? cur.rgt[5'(W-1-(idx-OFF))] : cur.lft[5'(W-1-(idx-OFF))];
                else
                    sd_i = 1'($urandom_range(0, 1));
            end
        end
    end

    // Real-mic emulator for u_mic: MSB at rising edge 1, fixed pair.
    initial begin : mic_emu
        int           idx;
        logic         ch, pw;
        logic [W-1:0] w;
        idx = 0;
        pw = 1'b1;
        m_sd = 1'b0;
        forever begin
            @(negedge m_sck);
            #1;
            ch = m_ws;
            if (ch != pw) idx = 0; else idx++;
            pw = ch;
            repeat (2) @(posedge clk);
            w = ch ? 24'h7FFFFF : 24'h800000;
            if (idx >= 1 && idx <= W)
                m_sd = w[5'(W-idx)];
            else
                m_sd = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard: outputs must match the head pair for as long as valid_o is high.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (overrun_o) ovr_cnt++;
                if (valid_o) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected: left=%h right=%h, required no pending pair", left_o, right_o);
                    end else if (left_o !== exp_q[0].lft || right_o !== exp_q[0].rgt) begin
                        n_fail++;
                        $display("FAIL sb_pair: left=%h right=%h, required left=%h right=%h",
                                 left_o, right_o, exp_q[0].lft, exp_q[0].rgt);
                    end
                    if (ready_i) begin
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        got_cnt++;
                        last_l = left_o;
                        last_r = right_o;
                        d_prev = d_last;
                        d_last = cyc;
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic stop_and_drain(input string name);
        int n;
        enable_i = 1'b0;
        n = 0;
        while (busy_o !== 1'b0 && n < 2 * FRAME) begin tick(); n++; end
        tick();
        n_checks++;
        if (busy_o !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: busy=%b pending=%0d, required busy=0 pending=0", name, busy_o, exp_q.size());
        end
    endtask

    task automatic test_reset;
        repeat (3) tick();
        n_checks++; if (sck_o !== 1'b0)    begin n_fail++; $display("FAIL reset_sck: got %b, required 0", sck_o); end
        n_checks++; if (ws_o !== 1'b1)     begin n_fail++; $display("FAIL reset_ws: got %b, required 1", ws_o); end
        n_checks++; if (left_o !== '0)     begin n_fail++; $display("FAIL reset_left: got %h, required 0", left_o); end
        n_checks++; if (right_o !== '0)    begin n_fail++; $display("FAIL reset_right: got %h, required 0", right_o); end
        n_checks++; if (valid_o !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b, required 0", valid_o); end
        n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, required 0", overrun_o); end
        n_checks++; if (busy_o !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
        rst_i = 1'b0;
        repeat (4) tick();
        n_checks++; if (sck_o !== 1'b0 || ws_o !== 1'b1) begin
            n_fail++; $display("FAIL idle_bus: sck=%b ws=%b, required sck=0 ws=1", sck_o, ws_o);
        end
    endtask

    task automatic test_basic;
        int n, base;
        for (int i = 0; i < 3; i++) src_q.push_back({24'h123456, 24'hABCDEF});
        base = got_cnt;
        ready_i = 1'b1;
        tick();
        enable_i = 1'b1;
        tick();
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, required 1", busy_o); end
        n = 0;
        while (ws_o !== 1'b0 && n < 64) begin tick(); n++; end
        n_checks++; if (n != 8) begin n_fail++; $display("FAIL basic_start_latency: got %0d cycles, required 8", n); end
        n = 0;
        while (got_cnt < base + 3 && n < 4 * FRAME) begin tick(); n++; end
        n_checks++; if (got_cnt < base + 3) begin n_fail++; $display("FAIL basic_timeout: got %0d pairs, required 3", got_cnt - base); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_valid_pulse: got %b, required 0", valid_o); end
        n_checks++; if (d_last - d_prev != FRAME) begin
            n_fail++; $display("FAIL basic_period: got %0d cycles, required %0d", d_last - d_prev, FRAME);
        end
        n_checks++; if (last_l !== 24'h123456 || last_r !== 24'hABCDEF) begin
            n_fail++; $display("FAIL basic_pair: got %h/%h, required 123456/abcdef", last_l, last_r);
        end
    endtask

    task automatic test_stop;
        int n, base;
        base = got_cnt;
        n = 0;
        while (ws_o !== 1'b0 && n < FRAME) begin tick(); n++; end
        repeat (40) tick();
        enable_i = 1'b0;
        n = 0;
        while (busy_o !== 1'b0 && n < 2 * FRAME) begin tick(); n++; end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b, required 0", busy_o); end
        n_checks++; if (ws_o !== 1'b1 || sck_o !== 1'b0) begin
            n_fail++; $display("FAIL stop_bus: ws=%b sck=%b, required ws=1 sck=0", ws_o, sck_o);
        end
        n_checks++; if (got_cnt != base + 1) begin n_fail++; $display("FAIL stop_final_pair: got %0d pairs, required 1", got_cnt - base); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stop_pending: got %0d, required 0", exp_q.size()); end
        repeat (20) tick();
        n_checks++; if (ws_o !== 1'b1 || sck_o !== 1'b0) begin
            n_fail++; $display("FAIL stop_hold: ws=%b sck=%b, required ws=1 sck=0", ws_o, sck_o);
        end
    endtask

    task automatic test_loopback;
        int n, base;
        logic [W-1:0] rl[8], rr[8];
        for (int i = 0; i < 8; i++) begin
            rl[i] = 24'h100000 + 24'(i) * 24'h010203;
            rr[i] = ~rl[i];
            src_q.push_back({rl[i], rr[i]});
        end
        base = got_cnt;
        enable_i = 1'b1;
        n = 0;
        while (got_cnt < base + 6 && n < 7 * FRAME) begin tick(); n++; end
        n_checks++; if (got_cnt < base + 6) begin n_fail++; $display("FAIL loop_timeout: got %0d pairs, required 6", got_cnt - base); end
        n_checks++; if (last_l !== rl[5] || last_r !== rr[5]) begin
            n_fail++; $display("FAIL loop_nth_pair: got %h/%h, required %h/%h", last_l, last_r, rl[5], rr[5]);
        end
        stop_and_drain("loop");
        src_q.delete();
    endtask

    task automatic test_backpressure;
        int n, base, base_ovr;
        pair_t bp[5];
        for (int i = 0; i < 5; i++) begin
            bp[i] = {24'h0A0000 + 24'(i), 24'hF00000 - 24'(i)};
            src_q.push_back(bp[i]);
        end
        frame_no = 0;
        drop_a = 2;
        drop_b = 3;
        base = got_cnt;
        base_ovr = ovr_cnt;
        ready_i = 1'b0;
        enable_i = 1'b1;
        n = 0;
        while (frame_no < 4 && n < 5 * FRAME) begin tick(); n++; end
        n_checks++; if (frame_no < 4) begin n_fail++; $display("FAIL bp_timeout: got frame %0d, required 4", frame_no); end
        n_checks++; if (ovr_cnt - base_ovr != 2) begin
            n_fail++; $display("FAIL bp_overrun: got %0d pulses, required 2", ovr_cnt - base_ovr);
        end
        ready_i = 1'b1;
        n = 0;
        while (got_cnt < base + 2 && n < 2 * FRAME) begin tick(); n++; end
        n_checks++; if (got_cnt < base + 2) begin n_fail++; $display("FAIL bp_deliver: got %0d pairs, required 2", got_cnt - base); end
        n_checks++; if (last_l !== bp[3].lft || last_r !== bp[3].rgt) begin
            n_fail++; $display("FAIL bp_frame4: got %h/%h, required %h/%h", last_l, last_r, bp[3].lft, bp[3].rgt);
        end
        stop_and_drain("bp");
        drop_a = -1;
        drop_b = -1;
        src_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        int n, base;
        frame_no = 0;
        ready_i = 1'b1;
        enable_i = 1'b1;
        n = 0;
        while (frame_no < 2 && n < 3 * FRAME) begin tick(); n++; end
        n = 0;
        while (ws_o !== 1'b1 && n < FRAME) begin tick(); n++; end
        repeat (60) tick();
        rst_i = 1'b1;
        #1;
        n_checks++; if (sck_o !== 1'b0 || ws_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_bus: sck=%b ws=%b busy=%b, required 0/1/0", sck_o, ws_o, busy_o);
        end
        n_checks++; if (valid_o !== 1'b0 || overrun_o !== 1'b0 || left_o !== '0 || right_o !== '0) begin
            n_fail++; $display("FAIL rst_outputs: valid=%b ovr=%b left=%h right=%h, required all 0", valid_o, overrun_o, left_o, right_o);
        end
        n_checks++; if (exp_q.size() != 1) begin n_fail++; $display("FAIL rst_partial: got %0d pending, required 1", exp_q.size()); end
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        enable_i = 1'b0;
        repeat (3) tick();
        snd_prev_ws = 1'b1;
        rst_i = 1'b0;
        tick();
        src_q.push_back({24'h5A5A5A, 24'hA5A5A5});
        base = got_cnt;
        enable_i = 1'b1;
        n = 0;
        while (got_cnt < base + 1 && n < 2 * FRAME) begin tick(); n++; end
        n_checks++; if (last_l !== 24'h5A5A5A || last_r !== 24'hA5A5A5) begin
            n_fail++; $display("FAIL rst_first_pair: got %h/%h, required 5a5a5a/a5a5a5", last_l, last_r);
        end
        stop_and_drain("rst");
    endtask

    task automatic test_real_mic;
        int n;
        m_ready = 1'b1;
        tick();
        m_enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (m_valid !== 1'b1 && n < 3 * FRAME) begin @(negedge clk); n++; end
            n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL mic_timeout: got valid=%b, required 1", m_valid); end
            n_checks++; if (m_left !== 24'h800000) begin n_fail++; $display("FAIL mic_left: got %h, required 800000", m_left); end
            n_checks++; if (m_right !== 24'h7FFFFF) begin n_fail++; $display("FAIL mic_right: got %h, required 7fffff", m_right); end
            @(negedge clk);
        end
        tick();
        m_enable = 1'b0;
        n = 0;
        while (m_busy !== 1'b0 && n < 2 * FRAME) begin tick(); n++; end
        n_checks++; if (m_busy !== 1'b0 || m_ws !== 1'b1 || m_sck !== 1'b0) begin
            n_fail++; $display("FAIL mic_stop: busy=%b ws=%b sck=%b, required 0/1/0", m_busy, m_ws, m_sck);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        enable_i = 1'b0;
        ready_i = 1'b1;
        m_enable = 1'b0;
        m_ready = 1'b1;
        n_checks = 0;
        n_fail = 0;
        got_cnt = 0;
        ovr_cnt = 0;
        frame_no = 0;
        drop_a = -1;
        drop_b = -1;
        d_last = 0;
        d_prev = 0;
        last_l = '0;
        last_r = '0;
        snd_prev_ws = 1'b1;
        test_reset();
        test_basic();
        test_stop();
        test_loopback();
        test_backpressure();
        test_reset_mid_frame();
        test_real_mic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
